// File: rtl/decode_wb_stage_p_if.sv
// ID-stage bus: IF/ID inputs, WB and EX/MEM feedback, branch/stall outputs, ID/EX bundle.
// The pipeline side uses the master modport; decode_wb_stage_p uses the slave modport.
interface decode_wb_stage_p_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            ifid_valid;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            exm_we;
    logic            exm_memread;
    logic [AW-1:0]   exm_addr;
    logic [XLEN-1:0] exm_data;

    logic            stall;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            jump;
    logic            idex_valid;
    logic [7:0]      idex_ctrl;
    logic [XLEN-1:0] idex_rs_data;
    logic [XLEN-1:0] idex_rt_data;
    logic [XLEN-1:0] idex_imm;
    logic [AW-1:0]   idex_rs;
    logic [AW-1:0]   idex_rt;
    logic [AW-1:0]   idex_rd;

    modport master (
        output ifid_valid, ifid_instr, ifid_pc,
        output wb_we, wb_addr, wb_data,
        output exm_we, exm_memread, exm_addr, exm_data,
        input  stall, br_taken, br_target, jump,
        input  idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
        input  idex_rs, idex_rt, idex_rd
    );

    modport slave (
        input  ifid_valid, ifid_instr, ifid_pc,
        input  wb_we, wb_addr, wb_data,
        input  exm_we, exm_memread, exm_addr, exm_data,
        output stall, br_taken, br_target, jump,
        output idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
        output idex_rs, idex_rt, idex_rd
    );
endinterface

// File: rtl/decode_wb_stage_p.sv
// MIPS decode/write-back stage: register file, control decode, ID forwarding, hazard stall FSM, ID/EX register.
// Optional macro BNE_EN adds opcode 0x05 (bne) using the beq hazard rules with an inverted compare.
module decode_wb_stage_p #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic                clk,
    input logic                rst_n,
    decode_wb_stage_p_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef BNE_EN
    localparam logic [5:0] OP_BNE  = 6'h05;
`endif

    typedef enum logic [1:0] {RUN, STALL2, STALL1} state_t;

    logic [XLEN-1:0] r_regs [NREGS];
    state_t          r_state;
    logic            r_idex_valid;
    logic [7:0]      r_idex_ctrl;
    logic [XLEN-1:0] r_idex_rs_data;
    logic [XLEN-1:0] r_idex_rt_data;
    logic [XLEN-1:0] r_idex_imm;
    logic [AW-1:0]   r_idex_rs;
    logic [AW-1:0]   r_idex_rt;
    logic [AW-1:0]   r_idex_rd;

    logic [5:0]      w_opcode;
    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic [7:0]      w_ctrl;
    logic            w_is_br;
    logic            w_br_ne;
    logic            w_jmp;
    logic            w_uses_rt;
    logic [AW-1:0]   w_id_dest;
    logic            w_ld_match;
    logic            w_alu_match;
    logic            w_exm_ld_match;
    logic            w_haz1;
    logic            w_haz2;
    logic            w_stall;
    logic            w_cond;

    assign w_opcode = bus.ifid_instr[31:26];
    assign w_rs     = AW'(bus.ifid_instr[25:21]);
    assign w_rt     = AW'(bus.ifid_instr[20:16]);
    assign w_rd     = AW'(bus.ifid_instr[15:11]);
    assign w_imm    = {{(XLEN-16){bus.ifid_instr[15]}}, bus.ifid_instr[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr != '0) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Priority: $0, EX/MEM ALU result, same-cycle WB write, register file.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        if (w_rs == '0)
            w_rs_data = '0;
        else if (bus.exm_we && !bus.exm_memread && bus.exm_addr == w_rs)
            w_rs_data = bus.exm_data;
        else if (bus.wb_we && bus.wb_addr == w_rs)
            w_rs_data = bus.wb_data;

        w_rt_data = r_regs[w_rt];
        if (w_rt == '0)
            w_rt_data = '0;
        else if (bus.exm_we && !bus.exm_memread && bus.exm_addr == w_rt)
            w_rt_data = bus.exm_data;
        else if (bus.wb_we && bus.wb_addr == w_rt)
            w_rt_data = bus.wb_data;
    end

    always_comb begin
        w_ctrl    = '0;
        w_is_br   = 1'b0;
        w_br_ne   = 1'b0;
        w_jmp     = 1'b0;
        w_uses_rt = 1'b0;
        case (w_opcode)
            OP_R:    begin w_ctrl = 8'b10010001; w_uses_rt = 1'b1; end
            OP_LW:   w_ctrl = 8'b01100011;
            OP_SW:   begin w_ctrl = 8'b00000110; w_uses_rt = 1'b1; end
            OP_BEQ:  begin w_ctrl = 8'b00001000; w_is_br = 1'b1; w_uses_rt = 1'b1; end
            OP_ADDI: w_ctrl = 8'b00000011;
            OP_J:    w_jmp = 1'b1;
`ifdef BNE_EN
            OP_BNE:  begin
                w_ctrl    = 8'b00001000;
                w_is_br   = 1'b1;
                w_br_ne   = 1'b1;
                w_uses_rt = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign w_id_dest = r_idex_ctrl[7] ? r_idex_rd : r_idex_rt;

    assign w_ld_match = r_idex_ctrl[6] && r_idex_rt != '0 &&
                        (r_idex_rt == w_rs || (w_uses_rt && r_idex_rt == w_rt));
    assign w_alu_match = r_idex_ctrl[0] && !r_idex_ctrl[6] && w_id_dest != '0 &&
                         (w_id_dest == w_rs || w_id_dest == w_rt);
    assign w_exm_ld_match = bus.exm_memread && bus.exm_addr != '0 &&
                            (bus.exm_addr == w_rs || bus.exm_addr == w_rt);

    assign w_haz2 = bus.ifid_valid && w_is_br && w_ld_match;
    assign w_haz1 = bus.ifid_valid &&
                    ((!w_is_br && w_ld_match) ||
                     (w_is_br && (w_alu_match || w_exm_ld_match)));

    // Hazards are re-derived every cycle; STALL2 only guarantees the second cycle of a
    // branch-after-load hold, while STALL1 is the closing cycle where live hazards alone decide.
    assign w_stall = rst_n && (w_haz1 || w_haz2 || r_state == STALL2);

    assign w_cond = w_br_ne ? (w_rs_data != w_rt_data) : (w_rs_data == w_rt_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_idex_valid   <= 1'b0;
            r_idex_ctrl    <= '0;
            r_idex_rs_data <= '0;
            r_idex_rt_data <= '0;
            r_idex_imm     <= '0;
            r_idex_rs      <= '0;
            r_idex_rt      <= '0;
            r_idex_rd      <= '0;
        end else begin
            case (r_state)
                RUN:     r_state <= w_haz2 ? STALL2 : (w_haz1 ? STALL1 : RUN);
                STALL2:  r_state <= STALL1;
                STALL1:  r_state <= RUN;
                default: r_state <= RUN;
            endcase

            r_idex_rs_data <= w_rs_data;
            r_idex_rt_data <= w_rt_data;
            r_idex_imm     <= w_imm;
            r_idex_rs      <= w_rs;
            r_idex_rt      <= w_rt;
            r_idex_rd      <= w_rd;
            if (w_stall || !bus.ifid_valid) begin
                r_idex_valid <= 1'b0;
                r_idex_ctrl  <= '0;
            end else begin
                r_idex_valid <= 1'b1;
                r_idex_ctrl  <= w_ctrl;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.br_taken     = bus.ifid_valid && w_is_br && w_cond && !w_stall;
    assign bus.br_target    = bus.ifid_pc + {w_imm[XLEN-3:0], 2'b00};
    assign bus.jump         = bus.ifid_valid && w_jmp;
    assign bus.idex_valid   = r_idex_valid;
    assign bus.idex_ctrl    = r_idex_ctrl;
    assign bus.idex_rs_data = r_idex_rs_data;
    assign bus.idex_rt_data = r_idex_rt_data;
    assign bus.idex_imm     = r_idex_imm;
    assign bus.idex_rs      = r_idex_rs;
    assign bus.idex_rt      = r_idex_rt;
    assign bus.idex_rd      = r_idex_rd;
endmodule

// File: tb/tb_decode_wb_stage_p.sv
// Directed bench for decode_wb_stage_p: reset, WB bypass, load-use, branch hazards, forwarding, decode, bne.
module tb_decode_wb_stage_p;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decode_wb_stage_p_if #(.XLEN(32), .NREGS(32)) bus ();

    decode_wb_stage_p #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.ifid_valid = 1'b0;
        bus.wb_we      = 1'b1;
        bus.wb_addr    = a;
        bus.wb_data    = d;
        tick();
        bus.wb_we      = 1'b0;
    endtask

    task automatic exm_clear;
        bus.exm_we      = 1'b0;
        bus.exm_memread = 1'b0;
        bus.exm_addr    = '0;
        bus.exm_data    = '0;
    endtask

    task automatic test_reset;
        wb_write(5'd1, 32'd5);
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h23, 5'd1, 5'd2, 16'h0);
        tick();
        bus.ifid_instr = enc_r(5'd2, 5'd2, 5'd3);
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b want 1", bus.stall); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_checks++; if (bus.idex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.idex_valid); end
        n_checks++; if (bus.idex_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00", bus.idex_ctrl); end
        n_checks++; if (bus.idex_rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs_data: got %h want 0", bus.idex_rs_data); end
        n_checks++; if (bus.idex_rt !== 5'd0) begin n_fail++; $display("FAIL reset_rt: got %0d want 0", bus.idex_rt); end
        bus.ifid_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_r(5'd1, 5'd2, 5'd3);
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h91) begin n_fail++; $display("FAIL add_ctrl: got %h want 91", bus.idex_ctrl); end
        n_checks++; if (bus.idex_rs_data !== 32'd5) begin n_fail++; $display("FAIL add_rs_data: got %h want 5", bus.idex_rs_data); end
        n_checks++; if (bus.idex_rt_data !== 32'd7) begin n_fail++; $display("FAIL add_rt_data: got %h want 7", bus.idex_rt_data); end
        n_checks++; if (bus.idex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", bus.idex_valid); end
        n_checks++; if (bus.idex_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d want 3", bus.idex_rd); end
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_wb_bypass;
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_r(5'd4, 5'd1, 5'd5);
        bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hAA;
        tick();
        bus.wb_we = 1'b0;
        n_checks++; if (bus.idex_rs_data !== 32'hAA) begin n_fail++; $display("FAIL wb_bypass_rs: got %h want aa", bus.idex_rs_data); end
        n_checks++; if (bus.idex_rt_data !== 32'd5) begin n_fail++; $display("FAIL wb_bypass_rt: got %h want 5", bus.idex_rt_data); end
        bus.ifid_instr = enc_r(5'd4, 5'd0, 5'd5);
        tick();
        n_checks++; if (bus.idex_rs_data !== 32'hAA) begin n_fail++; $display("FAIL regfile_r4: got %h want aa", bus.idex_rs_data); end
        n_checks++; if (bus.idex_rt_data !== 32'h0) begin n_fail++; $display("FAIL regfile_r0: got %h want 0", bus.idex_rt_data); end
        bus.ifid_instr = enc_r(5'd0, 5'd1, 5'd6);
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        tick();
        bus.wb_we = 1'b0;
        n_checks++; if (bus.idex_rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_no_bypass: got %h want 0", bus.idex_rs_data); end
        bus.ifid_instr = enc_r(5'd0, 5'd0, 5'd6);
        tick();
        n_checks++; if (bus.idex_rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_not_written: got %h want 0", bus.idex_rs_data); end
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use;
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h23, 5'd1, 5'd2, 16'h0);
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h63) begin n_fail++; $display("FAIL lw_ctrl: got %h want 63", bus.idex_ctrl); end
        bus.ifid_instr = enc_r(5'd2, 5'd2, 5'd3);
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: got %b want 1", bus.stall); end
        tick();
        bus.exm_we = 1'b1; bus.exm_memread = 1'b1; bus.exm_addr = 5'd2; bus.exm_data = 32'h0;
        #1;
        n_checks++; if (bus.idex_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble_valid: got %b want 0", bus.idex_valid); end
        n_checks++; if (bus.idex_ctrl !== 8'h00) begin n_fail++; $display("FAIL loaduse_bubble_ctrl: got %h want 00", bus.idex_ctrl); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %b want 0", bus.stall); end
        tick();
        exm_clear();
        n_checks++; if (bus.idex_valid !== 1'b1) begin n_fail++; $display("FAIL loaduse_issue_valid: got %b want 1", bus.idex_valid); end
        n_checks++; if (bus.idex_ctrl !== 8'h91) begin n_fail++; $display("FAIL loaduse_issue_ctrl: got %h want 91", bus.idex_ctrl); end
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_branch_after_load;
        wb_write(5'd6, 32'h33);
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h23, 5'd1, 5'd5, 16'h0);
        tick();
        bus.ifid_instr = enc_i(6'h04, 5'd5, 5'd6, 16'hFFFF);
        bus.ifid_pc    = 32'h100;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL bload_stall1: got %b want 1", bus.stall); end
        n_checks++; if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL bload_taken1: got %b want 0", bus.br_taken); end
        n_checks++; if (bus.br_target !== 32'hFC) begin n_fail++; $display("FAIL br_target_wrap: got %h want fc", bus.br_target); end
        tick();
        bus.exm_we = 1'b1; bus.exm_memread = 1'b1; bus.exm_addr = 5'd5; bus.exm_data = 32'h0;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL bload_stall2: got %b want 1", bus.stall); end
        n_checks++; if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL bload_taken2: got %b want 0", bus.br_taken); end
        n_checks++; if (bus.idex_valid !== 1'b0) begin n_fail++; $display("FAIL bload_bubble: got %b want 0", bus.idex_valid); end
        tick();
        exm_clear();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h33;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL bload_stall3: got %b want 0", bus.stall); end
        n_checks++; if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL bload_taken3: got %b want 1", bus.br_taken); end
        tick();
        bus.wb_we = 1'b0;
        n_checks++; if (bus.idex_ctrl !== 8'h08) begin n_fail++; $display("FAIL beq_ctrl: got %h want 08", bus.idex_ctrl); end
        n_checks++; if (bus.idex_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL beq_imm: got %h want ffffffff", bus.idex_imm); end
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_exm_forward;
        wb_write(5'd8, 32'h10);
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h08, 5'd0, 5'd7, 16'h0010);
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h03) begin n_fail++; $display("FAIL addi_ctrl: got %h want 03", bus.idex_ctrl); end
        n_checks++; if (bus.idex_imm !== 32'h10) begin n_fail++; $display("FAIL addi_imm: got %h want 10", bus.idex_imm); end
        bus.ifid_instr = enc_i(6'h04, 5'd7, 5'd8, 16'h0004);
        bus.ifid_pc    = 32'h200;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL balu_stall: got %b want 1", bus.stall); end
        tick();
        bus.exm_we = 1'b1; bus.exm_memread = 1'b0; bus.exm_addr = 5'd7; bus.exm_data = 32'h10;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL balu_release: got %b want 0", bus.stall); end
        n_checks++; if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL exm_fwd_taken: got %b want 1", bus.br_taken); end
        n_checks++; if (bus.br_target !== 32'h210) begin n_fail++; $display("FAIL br_target_fwd: got %h want 210", bus.br_target); end
        bus.exm_data = 32'h11;
        #1;
        n_checks++; if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL exm_fwd_nottaken: got %b want 0", bus.br_taken); end
        tick();
        exm_clear();
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_decode_misc;
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h2B, 5'd1, 5'd2, 16'h0004);
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h06) begin n_fail++; $display("FAIL sw_ctrl: got %h want 06", bus.idex_ctrl); end
        n_checks++; if (bus.idex_rt !== 5'd2) begin n_fail++; $display("FAIL sw_rt: got %0d want 2", bus.idex_rt); end
        bus.ifid_instr = {6'h02, 26'h10};
        #1;
        n_checks++; if (bus.jump !== 1'b1) begin n_fail++; $display("FAIL j_jump: got %b want 1", bus.jump); end
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h00) begin n_fail++; $display("FAIL j_ctrl: got %h want 00", bus.idex_ctrl); end
        n_checks++; if (bus.idex_valid !== 1'b1) begin n_fail++; $display("FAIL j_valid: got %b want 1", bus.idex_valid); end
        bus.ifid_instr = 32'hFC000000;
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h00) begin n_fail++; $display("FAIL unknown_ctrl: got %h want 00", bus.idex_ctrl); end
        n_checks++; if (bus.jump !== 1'b0) begin n_fail++; $display("FAIL unknown_jump: got %b want 0", bus.jump); end
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    task automatic test_bne;
        bus.ifid_valid = 1'b1;
        bus.ifid_instr = enc_i(6'h05, 5'd1, 5'd2, 16'h0008);
        #1;
`ifdef BNE_EN
        n_checks++; if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL bne_taken: got %b want 1", bus.br_taken); end
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h08) begin n_fail++; $display("FAIL bne_ctrl: got %h want 08", bus.idex_ctrl); end
`else
        n_checks++; if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL op05_taken: got %b want 0", bus.br_taken); end
        tick();
        n_checks++; if (bus.idex_ctrl !== 8'h00) begin n_fail++; $display("FAIL op05_ctrl: got %h want 00", bus.idex_ctrl); end
`endif
        bus.ifid_valid = 1'b0;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_checks = 0;
        n_fail = 0;
        bus.ifid_valid = 1'b0;
        bus.ifid_instr = '0;
        bus.ifid_pc = '0;
        bus.wb_we = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        exm_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_branch_after_load();
        test_exm_forward();
        test_decode_misc();
        test_bne();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
